// File: rtl/ahblite_decoder_mux.sv
// AHB-Lite decode/mux stage: address-phase decode to NPORT slaves,
// data-phase response mux, built-in default slave issuing two-cycle
// ERROR responses for unmapped active transfers, plus a decode-error log.
module ahblite_decoder_mux #(
  parameter int                     NPORT     = 5,
  parameter logic [NPORT-1:0]       PORT_EN   = {NPORT{1'b1}},
  parameter logic [NPORT*16-1:0]    PORT_BASE = {16'h5000, 16'h4001, 16'h4000, 16'h2000, 16'h0000},
  parameter logic [NPORT*16-1:0]    PORT_LAST = {16'h5000, 16'h4005, 16'h4000, 16'h2000, 16'h0000}
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  output logic [NPORT-1:0]      HSEL,
  input  logic [NPORT-1:0]      HREADYOUT_S,
  input  logic [NPORT-1:0]      HRESP_S,
  input  logic [NPORT*32-1:0]   HRDATA_S,
  output logic                  HREADY,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  input  logic                  ERR_CLR,
  output logic [7:0]            ERR_CNT,
  output logic [31:0]           ERR_ADDR
);
  localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;

  localparam logic [1:0] DS_IDLE = 2'd0;
  localparam logic [1:0] DS_ERR1 = 2'd1;
  localparam logic [1:0] DS_ERR2 = 2'd2;

  logic [NPORT-1:0] hsel_c;
  logic [IW-1:0]    hit_idx;
  logic             hit;
  logic             trans_act;
  logic             err_start;

  logic [IW-1:0] dsel_idx_d, dsel_idx_q;
  logic          dsel_def_d, dsel_def_q;
  logic [1:0]    ds_d, ds_q;
  logic [7:0]    err_cnt_d, err_cnt_q;
  logic [31:0]   err_addr_d, err_addr_q;

  logic ds_ready, ds_resp;

  // Priority range decode: lowest-index enabled port wins, so HSEL is at most one-hot.
  always_comb begin
    hsel_c  = '0;
    hit_idx = '0;
    hit     = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      if (!hit && PORT_EN[i] &&
          (HADDR[31:16] >= PORT_BASE[16*i +: 16]) &&
          (HADDR[31:16] <= PORT_LAST[16*i +: 16])) begin
        hsel_c[i] = 1'b1;
        hit_idx   = IW'(i);
        hit       = 1'b1;
      end
    end
  end

  assign HSEL      = hsel_c;
  assign trans_act = (HTRANS == 2'b10) || (HTRANS == 2'b11);
  // An unmapped NONSEQ/SEQ accepted this cycle starts a default-slave error.
  assign err_start = HREADY && !hit && trans_act;

  // Default-slave outputs per state.
  always_comb begin
    ds_ready = 1'b1;
    ds_resp  = 1'b0;
    case (ds_q)
      DS_ERR1: begin ds_ready = 1'b0; ds_resp = 1'b1; end
      DS_ERR2: begin ds_ready = 1'b1; ds_resp = 1'b1; end
      default: begin ds_ready = 1'b1; ds_resp = 1'b0; end
    endcase
  end

  // Data-phase mux; the selected slave drives the master combinationally.
  always_comb begin
    HREADY = ds_ready;
    HRESP  = ds_resp;
    HRDATA = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (!dsel_def_q && (dsel_idx_q == IW'(i))) begin
        HREADY = HREADYOUT_S[i];
        HRESP  = HRESP_S[i];
        HRDATA = HRDATA_S[32*i +: 32];
      end
    end
  end

  // Next-state: data-phase select, default-slave FSM and error log.
  always_comb begin
    dsel_idx_d = dsel_idx_q;
    dsel_def_d = dsel_def_q;
    if (HREADY) begin
      dsel_idx_d = hit_idx;
      dsel_def_d = !hit;
    end

    ds_d = ds_q;
    case (ds_q)
      DS_IDLE: if (err_start) ds_d = DS_ERR1;
      DS_ERR1: ds_d = DS_ERR2;
      DS_ERR2: ds_d = err_start ? DS_ERR1 : DS_IDLE;
      default: ds_d = DS_IDLE;
    endcase

    err_addr_d = err_start ? HADDR : err_addr_q;
    if (ERR_CLR)
      err_cnt_d = err_start ? 8'd1 : 8'd0;
    else if (err_start && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
    else
      err_cnt_d = err_cnt_q;
  end

  // State registers; reset parks the data phase on the idle default slave.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dsel_idx_q <= '0;
      dsel_def_q <= 1'b1;
      ds_q       <= DS_IDLE;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else begin
      dsel_idx_q <= dsel_idx_d;
      dsel_def_q <= dsel_def_d;
      ds_q       <= ds_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign ERR_CNT  = err_cnt_q;
  assign ERR_ADDR = err_addr_q;

endmodule
